shift_seq: RTL



---
 rtl/shift_defs.sv | 20 ++
 rtl/shift_stage.sv | 83 ++++++++
 rtl/shift_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/shift_defs.sv
// Shared encodings for the multi-cycle shift/rotate unit: operation codes,
// FSM state codes and the fixed operand geometry.
package shift_defs;

  localparam int SH_WIDTH  = 16;
  localparam int SH_CNT_W  = 4;
  localparam int SH_STAGES = 4;  // shift amounts 1, 2, 4, 8

  // Operation encodings.
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_STEP = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/shift_stage.sv
// Shared combinational shift stage plus the small mux primitives it is
// built from. One pass shifts/rotates by 1, 2, 4 or 8 (amt_sel = 0..3).

// Two-input mux.
module mux2_1 #(
  parameter int W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// Four-input mux.
module mux4_1 #(
  parameter int W = 16
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  // Select one of four data words.
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module shift_stage
  import shift_defs::*;
(
  input  logic [SH_WIDTH-1:0] in,
  input  logic [1:0]          op,
  input  logic [1:0]          amt_sel,
  output logic [SH_WIDTH-1:0] out
);

  // Result of each fixed-amount shifter, indexed by amt_sel.
  logic [SH_WIDTH-1:0] w_by_amt [SH_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SH_STAGES; gi++) begin : g_amt
      localparam int S = 1 << gi;
      // Candidates indexed by op code, so the op mux lines up with the encodings.
      logic [SH_WIDTH-1:0] w_cand [4];

      assign w_cand[OP_ROL] = {in[SH_WIDTH-1-S:0], in[SH_WIDTH-1:SH_WIDTH-S]};
      assign w_cand[OP_SLL] = {in[SH_WIDTH-1-S:0], {S{1'b0}}};
      // Fill with the current sign bit; repeated stages keep the sign intact.
      assign w_cand[OP_SRA] = {{S{in[SH_WIDTH-1]}}, in[SH_WIDTH-1:S]};
      assign w_cand[OP_SRL] = {{S{1'b0}}, in[SH_WIDTH-1:S]};

      mux4_1 #(.W(SH_WIDTH)) u_op_mux (
        .sel (op),
        .d0  (w_cand[0]),
        .d1  (w_cand[1]),
        .d2  (w_cand[2]),
        .d3  (w_cand[3]),
        .y   (w_by_amt[gi])
      );
    end
  endgenerate

  mux4_1 #(.W(SH_WIDTH)) u_amt_mux (
    .sel (amt_sel),
    .d0  (w_by_amt[0]),
    .d1  (w_by_amt[1]),
    .d2  (w_by_amt[2]),
    .d3  (w_by_amt[3]),
    .y   (out)
  );

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle 16-bit shift/rotate unit. One shared shift stage is applied
// four times (amounts 1, 2, 4, 8), each pass gated by one bit of the count.
// Fixed latency: accept, four STEP cycles, then a one-cycle done pulse.
module shift_seq
  import shift_defs::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int CNT_W = SH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  logic [1:0]       r_state;
  logic [1:0]       r_stage;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_data_next;
  logic             w_ready;

  assign w_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);

  shift_stage u_stage (
    .in      (r_data),
    .op      (r_op),
    .amt_sel (r_stage),
    .out     (w_shifted)
  );

  // Apply this stage's shift only if the matching count bit is set.
  mux2_1 #(.W(WIDTH)) u_gate (
    .sel (r_cnt[r_stage]),
    .d0  (r_data),
    .d1  (w_shifted),
    .y   (w_data_next)
  );

  // Sequencer: accept when ready, step four times, publish result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_stage <= 2'd0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_op    <= OP_ROL;
      r_out   <= '0;
    end else begin
      case (r_state)
        ST_STEP: begin
          r_data  <= w_data_next;
          r_stage <= r_stage + 2'd1;
          if (r_stage == 2'd3) begin
            r_out   <= w_data_next;
            r_state <= ST_DONE;
          end
        end
        default: begin
          if (w_ready && start) begin
            r_data  <= in;
            r_cnt   <= cnt;
            r_op    <= op;
            r_stage <= 2'd0;
            r_state <= ST_STEP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Status outputs decode registered state only, so no input reaches them.
  assign busy = (r_state == ST_STEP);
  assign done = (r_state == ST_DONE);
  assign out  = r_out;

endmodule
